// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the read-path arbiter.
// Holds FSM encoding, channel field widths and response codes.
package axi_lite_pkg;

   localparam int AXI_PROT_W = 3;
   localparam int AXI_RESP_W = 2;

   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
   localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping, gives a one-hot grant and its encoded index.
module rr_arbiter #(
   parameter  int NUM_M = 4,
   localparam int IDX_W = $clog2(NUM_M)
) (
   input  logic [NUM_M-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NUM_M-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      int   j;
      logic found;
      j     = 0;
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = 0; k < NUM_M; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_M) j = j - NUM_M;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Shares one AXI4-Lite read path between NUM_M masters, one read
// outstanding, round-robin on AR, R routed back to the AR winner.
module axi_lite_rd_arbiter
   import axi_lite_pkg::*;
#(
   parameter int NUM_M  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic [NUM_M-1:0]           s_arvalid,
   output logic [NUM_M-1:0]           s_arready,
   input  logic [NUM_M*ADDR_W-1:0]    s_araddr,
   input  logic [NUM_M*AXI_PROT_W-1:0] s_arprot,
   output logic [NUM_M-1:0]           s_rvalid,
   input  logic [NUM_M-1:0]           s_rready,
   output logic [DATA_W-1:0]          s_rdata,
   output logic [AXI_RESP_W-1:0]      s_rresp,
   output logic                       m_arvalid,
   input  logic                       m_arready,
   output logic [ADDR_W-1:0]          m_araddr,
   output logic [AXI_PROT_W-1:0]      m_arprot,
   input  logic                       m_rvalid,
   output logic                       m_rready,
   input  logic [DATA_W-1:0]          m_rdata,
   input  logic [AXI_RESP_W-1:0]      m_rresp
);

   localparam int IDX_W = $clog2(NUM_M);

   rd_state_e        state;
   rd_state_e        nstate;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] grant;
   logic [NUM_M-1:0] arb_gnt;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_any;
   logic             ar_take;
   logic             r_done;

   rr_arbiter #(.NUM_M(NUM_M)) u_rr (
      .req   (s_arvalid),
      .ptr   (ptr),
      .grant (arb_gnt),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign ar_take = (state == ST_IDLE) && arb_any;
   assign r_done  = (state == ST_DATA) && m_rvalid && s_rready[grant];

   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) state <= ST_IDLE;
      else         state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         ST_IDLE: if (arb_any)   nstate = ST_ADDR;
         ST_ADDR: if (m_arready) nstate = ST_DATA;
         ST_DATA: if (r_done)    nstate = ST_IDLE;
         default:                nstate = ST_IDLE;
      endcase
   end

   // AR fields are captured at the master handshake so the slave sees
   // a stable request no matter what the master does afterwards.
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         ptr      <= '0;
         grant    <= '0;
         m_araddr <= '0;
         m_arprot <= '0;
      end else begin
         if (ar_take) begin
            grant    <= arb_idx;
            m_araddr <= s_araddr[arb_idx*ADDR_W +: ADDR_W];
            m_arprot <= s_arprot[arb_idx*AXI_PROT_W +: AXI_PROT_W];
         end
         if (r_done) begin
            if (grant == IDX_W'(NUM_M-1)) ptr <= '0;
            else                          ptr <= grant + 1'b1;
         end
      end
   end

   always_comb begin
      s_arready = '0;
      s_rvalid  = '0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      unique case (state)
         ST_IDLE: s_arready = arb_gnt;
         ST_ADDR: m_arvalid = 1'b1;
         ST_DATA: begin
            s_rvalid[grant] = m_rvalid;
            m_rready        = s_rready[grant];
         end
         default: ;
      endcase
   end

   assign s_rdata = m_rdata;
   assign s_rresp = m_rresp;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter with hand-computed vectors.
module tb_axi_lite_rd_arbiter;

   localparam int NUM_M  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic                  ACLK;
   logic                  ARESETn;
   logic [NUM_M-1:0]      s_arvalid;
   logic [NUM_M-1:0]      s_arready;
   logic [NUM_M*ADDR_W-1:0] s_araddr;
   logic [NUM_M*3-1:0]    s_arprot;
   logic [NUM_M-1:0]      s_rvalid;
   logic [NUM_M-1:0]      s_rready;
   logic [DATA_W-1:0]     s_rdata;
   logic [1:0]            s_rresp;
   logic                  m_arvalid;
   logic                  m_arready;
   logic [ADDR_W-1:0]     m_araddr;
   logic [2:0]            m_arprot;
   logic                  m_rvalid;
   logic                  m_rready;
   logic [DATA_W-1:0]     m_rdata;
   logic [1:0]            m_rresp;

   int errors = 0;
   int checks = 0;

   axi_lite_rd_arbiter #(
      .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_araddr(s_araddr), .s_arprot(s_arprot),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_rdata(s_rdata), .s_rresp(s_rresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_araddr(m_araddr), .m_arprot(m_arprot),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_rdata(m_rdata), .m_rresp(m_rresp)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic set_ar(input int i, input logic [31:0] a,
                         input logic [2:0] p);
      s_araddr[i*ADDR_W +: ADDR_W] = a;
      s_arprot[i*3 +: 3]           = p;
   endtask

   // One full read with slave always ready and masters always R-ready.
   task automatic run_txn(input string tag, input logic [3:0] req,
                          input logic [3:0] gnt, input logic [31:0] addr,
                          input logic [2:0] prot, input logic [31:0] data,
                          input logic [1:0] resp);
      s_arvalid = req;
      m_arready = 1'b1;
      #1;
      chk({tag, ".arready"}, s_arready, gnt);
      chk({tag, ".arv_idle"}, m_arvalid, 1'b0);
      tick();
      #1;
      chk({tag, ".arvalid"}, m_arvalid, 1'b1);
      chk({tag, ".araddr"}, m_araddr, addr);
      chk({tag, ".arprot"}, m_arprot, prot);
      chk({tag, ".arready_addr"}, s_arready, 4'b0000);
      tick();
      m_rvalid = 1'b1;
      m_rdata  = data;
      m_rresp  = resp;
      s_rready = 4'b1111;
      #1;
      chk({tag, ".arv_data"}, m_arvalid, 1'b0);
      chk({tag, ".rvalid"}, s_rvalid, gnt);
      chk({tag, ".rdata"}, s_rdata, data);
      chk({tag, ".rresp"}, s_rresp, resp);
      chk({tag, ".rready"}, m_rready, 1'b1);
      tick();
      m_rvalid = 1'b0;
      s_rready = 4'b0000;
   endtask

   initial begin
      ARESETn   = 1'b1;
      s_arvalid = '0;
      s_araddr  = '0;
      s_arprot  = '0;
      s_rready  = '0;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      m_rresp   = 2'b00;

      repeat (2) tick();
      chk("rst.arvalid", m_arvalid, 1'b0);
      chk("rst.araddr", m_araddr, 32'h0);
      chk("rst.arprot", m_arprot, 3'b000);
      chk("rst.arready", s_arready, 4'b0000);
      chk("rst.rvalid", s_rvalid, 4'b0000);
      chk("rst.rready", m_rready, 1'b0);
      ARESETn = 1'b0;
      tick();

      // stray slave R in IDLE must not reach any master
      m_rvalid = 1'b1;
      s_rready = 4'b1111;
      #1;
      chk("stray.rvalid", s_rvalid, 4'b0000);
      chk("stray.rready", m_rready, 1'b0);
      tick();
      m_rvalid = 1'b0;
      s_rready = 4'b0000;
      tick();

      // single request from master 2
      set_ar(2, 32'h0000_1000, 3'b010);
      run_txn("single", 4'b0100, 4'b0100, 32'h0000_1000, 3'b010,
              32'hDEAD_BEEF, 2'b00);
      s_arvalid = '0;

      // ptr=3: masters 0 and 3 request, 3 wins then 0
      set_ar(0, 32'h0000_0A00, 3'b001);
      set_ar(3, 32'h0000_3A00, 3'b100);
      run_txn("wrap3", 4'b1001, 4'b1000, 32'h0000_3A00, 3'b100,
              32'h3333_0000, 2'b00);
      run_txn("wrap0", 4'b1001, 4'b0001, 32'h0000_0A00, 3'b001,
              32'h0000_AAAA, 2'b01);
      s_arvalid = '0;

      // all four continuously from reset
      ARESETn = 1'b1;
      tick();
      ARESETn = 1'b0;
      for (int i = 0; i < NUM_M; i++)
         set_ar(i, 32'h0000_2000 + i * 32'h10, 3'(i));
      run_txn("rr0", 4'b1111, 4'b0001, 32'h0000_2000, 3'd0,
              32'hA5A5_2000, 2'b00);
      run_txn("rr1", 4'b1111, 4'b0010, 32'h0000_2010, 3'd1,
              32'hA5A5_2010, 2'b00);
      run_txn("rr2", 4'b1111, 4'b0100, 32'h0000_2020, 3'd2,
              32'hA5A5_2020, 2'b00);
      run_txn("rr3", 4'b1111, 4'b1000, 32'h0000_2030, 3'd3,
              32'hA5A5_2030, 2'b11);
      run_txn("rr4", 4'b1111, 4'b0001, 32'h0000_2000, 3'd0,
              32'hA5A5_2001, 2'b00);
      s_arvalid = '0;

      // ptr=1: slave stalls AR, then master 1 stalls R with SLVERR
      set_ar(1, 32'h0000_5110, 3'b110);
      s_arvalid = 4'b0011;
      m_arready = 1'b0;
      #1;
      chk("stall.arready", s_arready, 4'b0010);
      tick();
      s_araddr[ADDR_W +: ADDR_W] = 32'hFFFF_FFFF;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("stall.arvalid%0d", c), m_arvalid, 1'b1);
         chk($sformatf("stall.araddr%0d", c), m_araddr, 32'h0000_5110);
         chk($sformatf("stall.arready%0d", c), s_arready, 4'b0000);
         tick();
      end
      m_arready = 1'b1;
      #1;
      chk("stall.arprot", m_arprot, 3'b110);
      tick();
      m_rvalid = 1'b1;
      m_rdata  = 32'h0BAD_0001;
      m_rresp  = 2'b10;
      s_rready = 4'b1101;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("rstall.rready%0d", c), m_rready, 1'b0);
         chk($sformatf("rstall.rvalid%0d", c), s_rvalid, 4'b0010);
         chk($sformatf("rstall.arready%0d", c), s_arready, 4'b0000);
         tick();
      end
      s_rready = 4'b0010;
      #1;
      chk("rstall.release", m_rready, 1'b1);
      chk("rstall.rresp", s_rresp, 2'b10);
      chk("rstall.rdata", s_rdata, 32'h0BAD_0001);
      tick();
      m_rvalid = 1'b0;
      s_rready = 4'b0000;
      set_ar(0, 32'h0000_0C00, 3'b011);
      run_txn("pend0", 4'b0001, 4'b0001, 32'h0000_0C00, 3'b011,
              32'h1234_5678, 2'b00);
      s_arvalid = '0;

      // reset in ADDR (ptr=1, master 2 granted)
      set_ar(2, 32'h0000_7000, 3'b101);
      s_arvalid = 4'b0100;
      m_arready = 1'b0;
      #1;
      chk("mid.arready", s_arready, 4'b0100);
      tick();
      s_arvalid = '0;
      #1;
      chk("mid.arvalid_pre", m_arvalid, 1'b1);
      ARESETn = 1'b1;
      #1;
      chk("mid.arvalid", m_arvalid, 1'b0);
      chk("mid.araddr", m_araddr, 32'h0);
      chk("mid.arprot", m_arprot, 3'b000);
      chk("mid.arready", s_arready, 4'b0000);
      chk("mid.rvalid", s_rvalid, 4'b0000);
      tick();
      ARESETn = 1'b0;
      s_arvalid = 4'b1001;
      #1;
      chk("mid.ptr0", s_arready, 4'b0001);
      set_ar(1, 32'h0000_1100, 3'b001);
      run_txn("mid.m1", 4'b0010, 4'b0010, 32'h0000_1100, 3'b001,
              32'hCAFE_0011, 2'b00);
      s_arvalid = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Shares one AXI4-Lite read path (AR + R channels) between NUM_M requesting masters and one slave.
- Round-robin arbitration on AR; exactly one read outstanding at a time.
- The R response is routed back to the master that won the AR grant.
- Sits between the master-side read-address logic and the slave-side read-address/data logic.

Parameters:
- NUM_M, 4, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-high.
- s_arvalid  in  NUM_M  per-master AR valid.
- s_arready  out  NUM_M  per-master AR ready.
- s_araddr  in  NUM_M*ADDR_W  per-master address; master i uses slice [i*ADDR_W +: ADDR_W].
- s_arprot  in  NUM_M*3  per-master protection bits.
- s_rvalid  out  NUM_M  per-master R valid.
- s_rready  in  NUM_M  per-master R ready.
- s_rdata  out  DATA_W  read data, broadcast to all masters; qualified by s_rvalid.
- s_rresp  out  2  read response, broadcast; qualified by s_rvalid.
- m_arvalid  out  1  AR valid to slave.
- m_arready  in  1  AR ready from slave.
- m_araddr  out  ADDR_W  registered address to slave.
- m_arprot  out  3  registered protection bits to slave.
- m_rvalid  in  1  R valid from slave.
- m_rready  out  1  R ready to slave.
- m_rdata  in  DATA_W  read data from slave.
- m_rresp  in  2  read response from slave.

Behaviour:
- Reset (ARESETn=1, async):
  - state=IDLE, ptr=0, grant=0.
  - m_arvalid=0, m_araddr=0, m_arprot=0.
  - s_arready=0, s_rvalid=0, m_rready=0.
- FSM states IDLE, ADDR, DATA.
- IDLE:
  - If any s_arvalid is high, winner g = first asserted index searching ptr, ptr+1, …, NUM_M-1, 0, …, ptr-1.
  - s_arready[g]=1 combinationally in that same cycle; all other s_arready bits are 0.
  - On that edge: latch s_araddr[g] and s_arprot[g] into m_araddr/m_arprot, latch grant=g, go to ADDR.
  - With no s_arvalid asserted, stay in IDLE with all s_arready=0.
- ADDR:
  - m_arvalid=1; m_araddr/m_arprot are held stable.
  - On m_arvalid && m_arready → DATA, m_arvalid=0 on the next cycle.
  - Latency: master accept edge to m_arvalid high = 1 cycle; minimum AR→slave handshake is 1 cycle after accept.
- DATA:
  - s_rvalid[grant]=m_rvalid; other s_rvalid bits are 0.
  - m_rready=s_rready[grant].
  - s_rdata=m_rdata and s_rresp=m_rresp (pass-through, combinational).
  - On m_rvalid && s_rready[grant] → IDLE, ptr = grant+1, wrapping NUM_M-1 → 0.
- Outside DATA: s_rvalid=0 and m_rready=0; a stray m_rvalid is ignored.
- s_arready is 0 in ADDR and DATA. No new grant is issued until the R handshake completes.
- Requests from non-granted masters stay pending; the arbiter never drops an unaccepted request.
- Fairness: a master that just completed has lowest priority next round. Worst-case wait is NUM_M-1 transactions.
- Simultaneous requests: exactly one winner per IDLE cycle, per the pointer rule.
- A master deasserting s_arvalid before acceptance is legal and simply not granted.
- Back-to-back transactions: the IDLE cycle after the R handshake is the earliest next accept (no zero-cycle turnaround).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The in-flight transaction is abandoned; the slave side is reset by the same ARESETn.
- m_rresp is passed unmodified, including SLVERR/DECERR.

Decomposition:
- Shared package axi_lite_pkg holds:
  - FSM state encoding (IDLE/ADDR/DATA).
  - AXI_PROT_W=3, AXI_RESP_W=2.
  - RESP codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- One sub-module rr_arbiter:
  - Inputs: req[NUM_M], ptr.
  - Output: one-hot grant and encoded index.
  - Purely combinational.
- The top holds the FSM, ptr and grant registers, AR registers and the R mux/demux.

Test Plan:
- Single request: NUM_M=4, master 2 sends 0x0000_1000, prot 3'b010; slave m_arready=1; RDATA 0xDEADBEEF, OKAY → s_arready[2] pulses 1 cycle; m_arvalid next cycle with 0x1000/3'b010; s_rvalid[2] only with 0xDEADBEEF/00; ptr=3.
- All four request continuously from reset, slave always ready → grant order 0,1,2,3,0; each master receives its own address-tagged data.
- Slave stalls m_arready low 5 cycles → m_arvalid held, m_araddr stable; s_arready all 0; no second grant until R completes.
- Master 1 holds s_rready low 3 cycles while m_rvalid=1, rresp=SLVERR → m_rready=0 for those cycles; completes on release; SLVERR seen on s_rresp.
- Wrap: ptr=3, masters 0 and 3 request → 3 wins, then 0.
- ARESETn pulsed high while in ADDR → outputs immediately at reset values; state IDLE, ptr=0; next request from master 1 proceeds normally.
